// File: rtl/iir_sample_feeder_if.sv
// ============================================================================
// Module  : iir_sample_feeder_if
// Brief   : Control/table-write/sample bus between a feeder controller and
//           iir_sample_feeder. FEEDER_LOOP_EN adds the `loop` request line.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface iir_sample_feeder_if #(
  parameter int DW = 32,
  parameter int AW = 7
);
  logic          start;
  logic          mode;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] i_signal;
  logic          clk_en;
  logic          sample_stb;
  logic          busy;
  logic          done;
`ifdef FEEDER_LOOP_EN
  logic          loop;

  modport master (
    output start, mode, wr_en, wr_addr, wr_data, loop,
    input  i_signal, clk_en, sample_stb, busy, done
  );
  modport slave (
    input  start, mode, wr_en, wr_addr, wr_data, loop,
    output i_signal, clk_en, sample_stb, busy, done
  );
`else
  modport master (
    output start, mode, wr_en, wr_addr, wr_data,
    input  i_signal, clk_en, sample_stb, busy, done
  );
  modport slave (
    input  start, mode, wr_en, wr_addr, wr_data,
    output i_signal, clk_en, sample_stb, busy, done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/iir_sample_feeder.sv
// ============================================================================
// Module  : iir_sample_feeder
// Brief   : Sample source for the IIR filter: impulse or table replay, one
//           sample every T clocks. FEEDER_LOOP_EN enables endless table replay.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_sample_feeder #(
  parameter int T       = 50,
  parameter int N       = 113,
  parameter int DW      = 32,
  parameter int IMP_AMP = 1000,
  parameter int AW      = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset_l,
  iir_sample_feeder_if.slave  bus
);

  localparam int              c_PW     = $clog2(T);
  localparam logic [c_PW-1:0] c_T_LAST = c_PW'(T - 1);
  localparam logic [AW-1:0]   c_I_LAST = AW'(N - 1);
  localparam logic [AW:0]     c_N_EXT  = (AW + 1)'(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_PW-1:0] r_presc;
  logic [AW-1:0]   r_idx;
  logic            r_mode;
  logic [DW-1:0]   r_signal;
  logic            r_clk_en;
  logic            r_stb;
  logic            r_busy;
  logic            r_done;
  logic [DW-1:0]   r_pref;
  logic [DW-1:0]   r_mem [0:N-1];

  logic            w_loop;
  logic            w_wr_ok;
  logic            w_wrap;
  logic [AW-1:0]   w_next_idx;

`ifdef FEEDER_LOOP_EN
  assign w_loop = bus.loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_wr_ok    = bus.wr_en && (r_state == S_IDLE || r_state == S_DONE) &&
                      ({1'b0, bus.wr_addr} < c_N_EXT);
  assign w_wrap     = (r_presc == c_T_LAST);
  assign w_next_idx = (r_idx == c_I_LAST) ? '0 : r_idx + 1'b1;

  // Table survives reset on purpose: a reloaded waveform is not lost on a run abort.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Next period's sample is fetched while the current one is held, so it is ready at the wrap.
  always_ff @(posedge clk) begin
    r_pref <= r_mem[w_next_idx];
  end

  always_ff @(posedge clk) begin
    if (reset_l) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_idx    <= '0;
      r_mode   <= 1'b0;
      r_signal <= '0;
      r_clk_en <= 1'b0;
      r_stb    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode   <= bus.mode;
            r_presc  <= '0;
            r_idx    <= '0;
            r_stb    <= 1'b1;
            r_clk_en <= 1'b1;
            r_busy   <= 1'b1;
            if (bus.mode) begin
              r_state  <= S_PLAY;
              // A same-cycle write to entry 0 has not landed in the table yet.
              r_signal <= (bus.wr_en && bus.wr_addr == '0) ? bus.wr_data : r_mem[0];
            end else begin
              r_state  <= S_LEAD;
              r_signal <= DW'(IMP_AMP);
            end
          end
        end

        S_LEAD: begin
          if (w_wrap) begin
            r_state  <= S_PLAY;
            r_presc  <= '0;
            r_signal <= '0;
            r_stb    <= 1'b1;
          end else begin
            r_presc <= r_presc + 1'b1;
            r_stb   <= 1'b0;
          end
        end

        S_PLAY: begin
          if (w_wrap) begin
            r_presc <= '0;
            if (r_idx == c_I_LAST && !(w_loop && r_mode)) begin
              r_state  <= S_DONE;
              r_idx    <= '0;
              r_signal <= '0;
              r_stb    <= 1'b0;
              r_clk_en <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_idx    <= w_next_idx;
              r_signal <= r_mode ? r_pref : '0;
              r_stb    <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
            r_stb   <= 1'b0;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.i_signal   = r_signal;
  assign bus.clk_en     = r_clk_en;
  assign bus.sample_stb = r_stb;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_iir_sample_feeder.sv
// ============================================================================
// Module  : tb_iir_sample_feeder
// Brief   : Self-checking bench for iir_sample_feeder (T=4 and T=2 instances,
//           N=3); FEEDER_LOOP_EN adds a looping replay scenario.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iir_sample_feeder;

  localparam int N   = 3;
  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int IMP = 1000;
  localparam int T1  = 4;
  localparam int T2  = 2;

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  iir_sample_feeder_if #(.DW(DW), .AW(AW)) bus1 ();
  iir_sample_feeder_if #(.DW(DW), .AW(AW)) bus2 ();

  iir_sample_feeder #(.T(T1), .N(N), .DW(DW), .IMP_AMP(IMP), .AW(AW)) u_dut1 (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus1.slave)
  );

  iir_sample_feeder #(.T(T2), .N(N), .DW(DW), .IMP_AMP(IMP), .AW(AW)) u_dut2 (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus2.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: table contents and the list of samples one run must emit
  logic [DW-1:0] tbl [N];
  logic [DW-1:0] exp_q [$];
  int inj_c       = -1;
  int abort_c     = -1;
  int flip_c      = -1;
  int loop_passes = 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic chk_outs(input string pfx, input bit d2, input logic [DW-1:0] e_sig,
                          input bit e_stb, input bit e_act, input bit e_done);
    chk({pfx, " i_signal"},   d2 ? bus2.i_signal   : bus1.i_signal,   e_sig);
    chk({pfx, " sample_stb"}, DW'(d2 ? bus2.sample_stb : bus1.sample_stb), DW'(e_stb));
    chk({pfx, " clk_en"},     DW'(d2 ? bus2.clk_en     : bus1.clk_en),     DW'(e_act));
    chk({pfx, " busy"},       DW'(d2 ? bus2.busy       : bus1.busy),       DW'(e_act));
    chk({pfx, " done"},       DW'(d2 ? bus2.done       : bus1.done),       DW'(e_done));
  endtask

  task automatic write_both(input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    bus1.wr_en = 1'b1; bus1.wr_addr = AW'(addr); bus1.wr_data = data;
    bus2.wr_en = 1'b1; bus2.wr_addr = AW'(addr); bus2.wr_data = data;
    @(negedge clk);
    bus1.wr_en = 1'b0;
    bus2.wr_en = 1'b0;
    if (addr < N) tbl[addr] = data;
  endtask

  task automatic run(input bit d2, input bit md, input bit same_wr, input logic [DW-1:0] same_data);
    int P;
    int L;
    string pfx;
    P = d2 ? T2 : T1;
    if (same_wr) tbl[0] = same_data;
    exp_q = {};
    if (!md) begin
      exp_q.push_back(DW'(IMP));
      for (int k = 0; k < N; k++) exp_q.push_back('0);
    end else begin
      for (int p = 0; p < loop_passes; p++)
        for (int k = 0; k < N; k++) exp_q.push_back(tbl[k]);
    end
    L = exp_q.size() * P;

    @(negedge clk);
    if (d2) begin bus2.start = 1'b1; bus2.mode = md; end
    else    begin bus1.start = 1'b1; bus1.mode = md; end
    if (same_wr) begin
      bus1.wr_en = 1'b1; bus1.wr_addr = '0; bus1.wr_data = same_data;
      bus2.wr_en = 1'b1; bus2.wr_addr = '0; bus2.wr_data = same_data;
    end
`ifdef FEEDER_LOOP_EN
    bus1.loop = (loop_passes > 1);
`endif
    @(negedge clk);
    bus1.start = 1'b0; bus2.start = 1'b0;
    bus1.wr_en = 1'b0; bus2.wr_en = 1'b0;

    for (int c = 1; c <= L + 2; c++) begin
      pfx = $sformatf("%s m%0d c%0d", d2 ? "dut2" : "dut1", md, c);
      if (c <= L)          chk_outs(pfx, d2, exp_q[(c - 1) / P], ((c - 1) % P) == 0, 1'b1, 1'b0);
      else if (c == L + 1) chk_outs(pfx, d2, '0, 1'b0, 1'b0, 1'b1);
      else                 chk_outs(pfx, d2, '0, 1'b0, 1'b0, 1'b0);

      if (!d2) begin
        bus1.start = 1'b0;
        bus1.wr_en = 1'b0;
        if (c == inj_c) begin
          bus1.start = 1'b1; bus1.wr_en = 1'b1; bus1.wr_addr = 2'd1; bus1.wr_data = 99;
        end
        if (inj_c > 0 && c == L + 1) bus1.start = 1'b1;
        if (c == flip_c) bus1.mode = ~bus1.mode;
`ifdef FEEDER_LOOP_EN
        if (loop_passes > 1 && c == (loop_passes - 1) * N * P + 2) bus1.loop = 1'b0;
`endif
      end

      if (c == abort_c) begin
        reset_l = 1'b1;
        @(negedge clk);
        reset_l = 1'b0;
        for (int r = 0; r < 3; r++) begin
          chk_outs($sformatf("abort r%0d", r), 1'b0, '0, 1'b0, 1'b0, 1'b0);
          @(negedge clk);
        end
        return;
      end
      @(negedge clk);
    end
    bus1.start = 1'b0;
  endtask

  initial begin
    reset_l = 1'b1;
    bus1.start = 1'b0; bus1.mode = 1'b0; bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
    bus2.start = 1'b0; bus2.mode = 1'b0; bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
`ifdef FEEDER_LOOP_EN
    bus1.loop = 1'b0;
    bus2.loop = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_outs("reset dut1", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_outs("reset dut2", 1'b1, '0, 1'b0, 1'b0, 1'b0);
    reset_l = 1'b0;

    // Impulse; mode toggled mid-run must not matter
    flip_c = 3;
    run(1'b0, 1'b0, 1'b0, '0);
    flip_c = -1;

    // Load 10/20/30; a write to the out-of-range address 3 is dropped
    write_both(0, 10);
    write_both(1, 20);
    write_both(2, 30);
    write_both(3, 32'hDEAD_BEEF);

    // Start + write while busy, and start during DONE: all ignored
    inj_c = 5;
    run(1'b0, 1'b1, 1'b0, '0);
    inj_c = -1;
    run(1'b1, 1'b1, 1'b0, '0);
    run(1'b0, 1'b1, 1'b0, '0);

    // Reset during period 1, then replay from the retained table
    abort_c = 6;
    run(1'b0, 1'b1, 1'b0, '0);
    abort_c = -1;
    run(1'b0, 1'b1, 1'b0, '0);

    // Same-cycle write to address 0 and start
    run(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB);
    run(1'b1, 1'b1, 1'b0, '0);

    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < N; k++) write_both(k, $urandom());
      write_both(3, $urandom());
      run(1'b0, 1'b1, 1'b0, '0);
      run(1'b1, 1'b1, 1'b0, '0);
      run(1'b1, 1'b0, 1'b0, '0);
    end

`ifdef FEEDER_LOOP_EN
    loop_passes = 3;
    run(1'b0, 1'b1, 1'b0, '0);
    loop_passes = 1;
    run(1'b0, 1'b0, 1'b0, '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
